// File: rtl/ptp_sched_pkg.sv
// Shared constants for the PTP sync scheduler: tx_type codes, request
// indices, FSM encoding and default timing parameters.
package ptp_sched_pkg;

  localparam logic [3:0] TX_SYNC  = 4'd1;
  localparam logic [3:0] TX_DREQ  = 4'd3;
  localparam logic [3:0] TX_DRESQ = 4'd4;

  // Request vector bit positions; higher index wins arbitration.
  localparam int REQ_N     = 3;
  localparam int REQ_SYNC  = 0;
  localparam int REQ_DREQ  = 1;
  localparam int REQ_DRESQ = 2;

  localparam int DEF_PERIOD_CYC  = 125000;
  localparam int DEF_TIMEOUT_CYC = 62500;
  localparam int DEF_MAX_RETRY   = 3;
  localparam int DEF_BACKOFF_CYC = 16;

  typedef enum logic [1:0] {
    ST_IDLE        = 2'd0,
    ST_WAIT_RESULT = 2'd1,
    ST_BACKOFF     = 2'd2
  } sched_state_e;

endpackage

// File: rtl/ptp_tx_arb.sv
// Fixed-priority merge of the PTP transmit requests onto one req/ack
// channel, with a one-deep pending flag per request type.
module ptp_tx_arb
  import ptp_sched_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [REQ_N-1:0] req_pulse,
  input  logic             tx_ack,
  output logic             tx_req,
  output logic [3:0]       tx_type
);

  logic [REQ_N-1:0] pend_q, pend_d, pend_eff, gnt;
  logic             tx_req_q, tx_req_d;
  logic [3:0]       tx_type_q, tx_type_d;

  always_comb begin
    pend_eff  = pend_q | req_pulse;
    gnt       = '0;
    tx_req_d  = tx_req_q;
    tx_type_d = tx_type_q;
    if (tx_req_q) begin
      if (tx_ack) begin
        tx_req_d  = 1'b0;
        tx_type_d = 4'd0;
      end
    end else if (enable) begin
      if (pend_eff[REQ_DRESQ]) begin
        gnt[REQ_DRESQ] = 1'b1;
        tx_type_d      = TX_DRESQ;
      end else if (pend_eff[REQ_DREQ]) begin
        gnt[REQ_DREQ] = 1'b1;
        tx_type_d     = TX_DREQ;
      end else if (pend_eff[REQ_SYNC]) begin
        gnt[REQ_SYNC] = 1'b1;
        tx_type_d     = TX_SYNC;
      end
      tx_req_d = |gnt;
    end
    // A pulse landing while its stale flag is being granted must survive.
    pend_d = (pend_eff & ~gnt) | (req_pulse & pend_q & gnt);
    if (!enable) pend_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q    <= '0;
      tx_req_q  <= 1'b0;
      tx_type_q <= 4'd0;
    end else begin
      pend_q    <= pend_d;
      tx_req_q  <= tx_req_d;
      tx_type_q <= tx_type_d;
    end
  end

  assign tx_req  = tx_req_q;
  assign tx_type = tx_type_q;

endmodule

// File: rtl/ptp_sync_sched.sv
// PTP sync period scheduler: period tick, slave timeout/retry supervision
// and the merged transmit request channel toward tx_proc.
module ptp_sync_sched
  import ptp_sched_pkg::*;
#(
  parameter int PERIOD_CYC  = DEF_PERIOD_CYC,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
  parameter int MAX_RETRY   = DEF_MAX_RETRY,
  parameter int BACKOFF_CYC = DEF_BACKOFF_CYC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [1:0]  device_role,
  input  logic        send_dreq_pkt,
  input  logic        send_dresq_pkt,
  input  logic        status_ok,
  input  logic        error,
  output logic        sync_start,
  output logic        tx_req,
  output logic [3:0]  tx_type,
  input  logic        tx_ack,
  output logic        sync_fail,
  output logic [31:0] ok_cnt,
  output logic [31:0] fail_cnt
);

  localparam int CW   = $clog2(PERIOD_CYC);
  localparam int TMAX = (TIMEOUT_CYC > BACKOFF_CYC) ? TIMEOUT_CYC : BACKOFF_CYC;
  localparam int TW   = $clog2(TMAX + 1);

  sched_state_e     state_q, state_d;
  logic [CW-1:0]    per_q, per_d;
  logic [TW-1:0]    tmr_q, tmr_d;
  logic [3:0]       att_q, att_d;
  logic             sync_start_q, sync_start_d;
  logic             sync_fail_q, sync_fail_d;
  logic [31:0]      ok_cnt_q, ok_cnt_d, fail_cnt_q, fail_cnt_d;
  logic             tick, sync_pend;
  logic [REQ_N-1:0] req_pulse;
  logic             unused_role;

  assign unused_role = device_role[1];
  assign tick        = enable && (per_q == CW'(PERIOD_CYC - 1));

  always_comb begin
    per_d = per_q + CW'(1);
    if (!enable || tick) per_d = '0;
  end

  always_comb begin
    state_d      = state_q;
    tmr_d        = (tmr_q != '0) ? tmr_q - TW'(1) : tmr_q;
    att_d        = att_q;
    sync_start_d = 1'b0;
    sync_pend    = 1'b0;
    ok_cnt_d     = ok_cnt_q;
    fail_cnt_d   = fail_cnt_q;
    sync_fail_d  = sync_fail_q & ~status_ok;
    case (state_q)
      ST_IDLE: begin
        if (tick) begin
          sync_start_d = 1'b1;
          if (device_role[0]) begin
            sync_pend = 1'b1;
          end else begin
            state_d = ST_WAIT_RESULT;
            tmr_d   = TW'(TIMEOUT_CYC);
            att_d   = 4'd1;
          end
        end
      end
      ST_WAIT_RESULT: begin
        // Timer hits zero exactly TIMEOUT_CYC cycles after sync_start.
        if (status_ok) begin
          ok_cnt_d = ok_cnt_q + 32'd1;
          state_d  = ST_IDLE;
        end else if (error || tmr_q == '0) begin
          fail_cnt_d = fail_cnt_q + 32'd1;
          if (att_q < 4'(MAX_RETRY)) begin
            state_d = ST_BACKOFF;
            tmr_d   = TW'(BACKOFF_CYC - 1);
          end else begin
            sync_fail_d = 1'b1;
            state_d     = ST_IDLE;
          end
        end
      end
      ST_BACKOFF: begin
        if (tmr_q == '0) begin
          sync_start_d = 1'b1;
          att_d        = att_q + 4'd1;
          tmr_d        = TW'(TIMEOUT_CYC);
          state_d      = ST_WAIT_RESULT;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (!enable) begin
      state_d      = ST_IDLE;
      sync_start_d = 1'b0;
      sync_pend    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      per_q        <= '0;
      tmr_q        <= '0;
      att_q        <= 4'd0;
      sync_start_q <= 1'b0;
      sync_fail_q  <= 1'b0;
      ok_cnt_q     <= 32'd0;
      fail_cnt_q   <= 32'd0;
    end else begin
      state_q      <= state_d;
      per_q        <= per_d;
      tmr_q        <= tmr_d;
      att_q        <= att_d;
      sync_start_q <= sync_start_d;
      sync_fail_q  <= sync_fail_d;
      ok_cnt_q     <= ok_cnt_d;
      fail_cnt_q   <= fail_cnt_d;
    end
  end

  assign req_pulse = {send_dresq_pkt, send_dreq_pkt, sync_pend};

  ptp_tx_arb u_arb (
    .clk      (clk),
    .rst_n    (reset),
    .enable   (enable),
    .req_pulse(req_pulse),
    .tx_ack   (tx_ack),
    .tx_req   (tx_req),
    .tx_type  (tx_type)
  );

  assign sync_start = sync_start_q;
  assign sync_fail  = sync_fail_q;
  assign ok_cnt     = ok_cnt_q;
  assign fail_cnt   = fail_cnt_q;

endmodule

// File: tb/tb_ptp_sync_sched.sv
// Scoreboard bench for ptp_sync_sched: expected tx_types queued at stimulus
// time, popped on each tx_req rise; sync_start cycles logged and checked.
module tb_ptp_sync_sched;

  localparam int P = 100;
  localparam int T = 30;
  localparam int R = 3;
  localparam int B = 16;

  logic        clk = 1'b0;
  logic        rst_n, enable, dreq, dresq, sok, err, ack;
  logic [1:0]  role;
  logic        sync_start, tx_req, sync_fail;
  logic [3:0]  tx_type;
  logic [31:0] ok_cnt, fail_cnt;

  int         checks = 0;
  int         fails  = 0;
  int         cyc    = 0;
  int         grants = 0;
  int         sync_cycs[$];
  logic [3:0] exp_tx[$];
  logic       auto_ack = 1'b1;
  logic       man_ack  = 1'b0;

  ptp_sync_sched #(
    .PERIOD_CYC(P), .TIMEOUT_CYC(T), .MAX_RETRY(R), .BACKOFF_CYC(B)
  ) dut (
    .clk(clk), .reset(rst_n), .enable(enable), .device_role(role),
    .send_dreq_pkt(dreq), .send_dresq_pkt(dresq), .status_ok(sok), .error(err),
    .sync_start(sync_start), .tx_req(tx_req), .tx_type(tx_type), .tx_ack(ack),
    .sync_fail(sync_fail), .ok_cnt(ok_cnt), .fail_cnt(fail_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0d exp=%0d (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic wait_sync(input int n, input int budget);
    int k = 0;
    while (sync_cycs.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk("sync_wait", sync_cycs.size(), n);
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Monitor: log sync_start cycles, score each new tx request.
  initial begin
    logic       tx_prev = 1'b0;
    logic [3:0] held_t  = 4'd0;
    logic [3:0] exp_t;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (sync_start) sync_cycs.push_back(cyc);
        if (tx_req && !tx_prev) begin
          if (exp_tx.size() > 0) exp_t = exp_tx.pop_front();
          else exp_t = 4'hF;
          chk("tx_type", tx_type, exp_t);
          held_t = tx_type;
          grants++;
        end else if (tx_req) begin
          chk("tx_hold", tx_type, held_t);
        end
      end
      tx_prev = tx_req;
    end
  end

  // tx_proc model: ack 2 cycles after the request rises, or manual.
  initial begin
    int ack_cnt = 0;
    ack = 1'b0;
    forever begin
      @(negedge clk);
      if (!auto_ack) ack = man_ack;
      else if (tx_req && !ack) begin
        ack_cnt++;
        if (ack_cnt == 3) ack = 1'b1;
      end else begin
        ack = 1'b0;
        ack_cnt = 0;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int e, s, s2, s3, s4, r, g0;
    rst_n = 1'b0; enable = 1'b0; role = 2'b01;
    dreq = 1'b0; dresq = 1'b0; sok = 1'b0; err = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_sync_start", sync_start, 0);
    chk("rst_tx_req", tx_req, 0);
    chk("rst_tx_type", tx_type, 0);
    chk("rst_sync_fail", sync_fail, 0);
    chk("rst_ok_cnt", ok_cnt, 0);
    chk("rst_fail_cnt", fail_cnt, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Master periodic Sync
    sync_cycs.delete();
    enable = 1'b1; e = cyc;
    repeat (3) exp_tx.push_back(4'd1);
    wait_sync(3, 400);
    chk("m_first", sync_cycs[0] - e, P);
    chk("m_gap1", sync_cycs[1] - sync_cycs[0], P);
    chk("m_gap2", sync_cycs[2] - sync_cycs[1], P);
    chk("m_ok_cnt", ok_cnt, 0);

    // Delay_Resp collides with the Sync tick
    wait_cyc(e + 4*P - 1);
    dresq = 1'b1;
    exp_tx.push_back(4'd4);
    exp_tx.push_back(4'd1);
    @(negedge clk); dresq = 1'b0;
    repeat (15) @(negedge clk);
    enable = 1'b0;
    chk("m_sync4", sync_cycs[3] - e, 4*P);
    chk("m_exp_left", exp_tx.size(), 0);
    chk("m_grants", grants, 5);

    // Coalescing and re-set on grant cycle
    @(negedge clk);
    enable = 1'b1;
    repeat (3) exp_tx.push_back(4'd3);
    @(negedge clk); dreq = 1'b1;
    @(negedge clk);
    @(negedge clk); dreq = 1'b0;
    repeat (2) @(negedge clk);
    dreq = 1'b1;
    @(negedge clk); dreq = 1'b0;
    repeat (20) @(negedge clk);
    enable = 1'b0;
    chk("c_exp_left", exp_tx.size(), 0);
    chk("c_grants", grants, 8);

    // Slave success
    @(negedge clk);
    role = 2'b00; enable = 1'b1; e = cyc;
    sync_cycs.delete();
    wait_sync(1, 150);
    s = sync_cycs[0];
    chk("s_first", s - e, P);
    wait_cyc(s + 20);
    sok = 1'b1;
    @(negedge clk); sok = 1'b0;
    @(negedge clk);
    chk("s_ok_cnt", ok_cnt, 1);
    chk("s_sync_fail", sync_fail, 0);

    // Slave timeout with retries
    wait_sync(2, 150);
    s2 = sync_cycs[1];
    chk("t_period", s2 - s, P);
    wait_sync(4, 150);
    chk("t_retry1", sync_cycs[2] - s2, T + B + 1);
    chk("t_retry2", sync_cycs[3] - sync_cycs[2], T + B + 1);
    wait_cyc(s2 + 2*(T + B + 1) + T + 2);
    chk("t_fail_cnt", fail_cnt, R);
    chk("t_sync_fail", sync_fail, 1);
    chk("t_no_more", sync_cycs.size(), 4);
    wait_sync(5, 150);
    s3 = sync_cycs[4];
    chk("t_next", s3 - s2, 2*P);
    wait_cyc(s3 + 5);
    sok = 1'b1;
    @(negedge clk); sok = 1'b0;
    @(negedge clk);
    chk("t_fail_clr", sync_fail, 0);
    chk("t_ok_cnt", ok_cnt, 2);

    // Reset in WAIT_RESULT
    wait_sync(6, 150);
    s4 = sync_cycs[5];
    chk("r_period", s4 - s3, P);
    wait_cyc(s4 + 5);
    rst_n = 1'b0;
    #1;
    chk("r_ok_cnt", ok_cnt, 0);
    chk("r_fail_cnt", fail_cnt, 0);
    chk("r_tx_req", tx_req, 0);
    chk("r_sync_start", sync_start, 0);
    @(negedge clk);
    rst_n = 1'b1; r = cyc;
    sync_cycs.delete();
    wait_sync(1, 150);
    chk("r_restart", sync_cycs[0] - r, P);
    wait_cyc(sync_cycs[0] + 3);
    sok = 1'b1;
    @(negedge clk); sok = 1'b0;
    @(negedge clk);
    chk("r_ok_after", ok_cnt, 1);

    // enable drop with an outstanding request and two pending flags
    auto_ack = 1'b0;
    dresq = 1'b1;
    exp_tx.push_back(4'd4);
    @(negedge clk); dresq = 1'b0;
    repeat (2) @(negedge clk);
    dresq = 1'b1; dreq = 1'b1;
    @(negedge clk); dresq = 1'b0; dreq = 1'b0;
    enable = 1'b0;
    repeat (5) @(negedge clk);
    chk("d_req_held", tx_req, 1);
    chk("d_type_held", tx_type, 4);
    g0 = grants;
    man_ack = 1'b1;
    @(negedge clk); man_ack = 1'b0;
    @(negedge clk);
    chk("d_req_drop", tx_req, 0);
    repeat (20) @(negedge clk);
    chk("d_req_low", tx_req, 0);
    chk("d_no_grant", grants, g0);
    chk("d_exp_left", exp_tx.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
